gen_loop_walker: RTL and testbench

Sequential counterpart of a statically elaborated triangular nested generate loop. It walks, at run time, the same iteration space the unrolled hierarchy creates. For each outer index k it visits inner indices l = 0 .. 2^k-1 and emits one tuple (k, l, value = 2^k + l) per cycle over a valid/ready stream. It sits beside elaborated parameter tables and lets a testbench or runtime sequencer replay the per-iteration parameters in elaboration order.

---
 rtl/gen_loop_walker.sv | 175 +++++++++++++++++
 tb/tb_gen_loop_walker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gen_loop_walker.sv
`default_nettype none
// ============================================================================
// Module   : gen_loop_walker
// Purpose  : Run-time walker over a triangular nested iteration space.
//            For each outer index k = 0 .. NumOuter-1 it visits inner indices
//            l = 0 .. 2^k-1 and emits one tuple (k, l, 2^k + l) per accepted
//            transfer on a valid/ready stream, in elaboration order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   begin a walk (sampled only in IDLE)
//   clear_i      in   synchronous abort back to IDLE, no done pulse
//   busy_o       out  high while walking
//   done_o       out  one-cycle pulse after the final tuple is accepted
//   valid_o      out  tuple on the output bus is valid
//   ready_i      in   consumer accepts the tuple
//   outer_idx_o  out  current k
//   inner_idx_o  out  current l
//   value_o      out  2^k + l, zero-extended
//   inner_last_o out  l == 2^k - 1
//   outer_last_o out  k == NumOuter - 1
//   count_o      out  tuples accepted in the current or most recent walk
// ============================================================================
module gen_loop_walker #(
  parameter int NumOuter = 3,
  parameter int IdxWidth = 8,
  parameter int ValWidth = 32,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [IdxWidth-1:0] outer_idx_o,
  output logic [IdxWidth-1:0] inner_idx_o,
  output logic [ValWidth-1:0] value_o,
  output logic                inner_last_o,
  output logic                outer_last_o,
  output logic [CntWidth-1:0] count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IdxWidth-1:0] LastOuter = IdxWidth'(NumOuter - 1);

  state_t              state;
  logic [IdxWidth-1:0] k_q;
  logic [IdxWidth-1:0] l_q;

  logic                xfer;
  logic                at_inner_end;
  logic                at_outer_end;
  logic [IdxWidth-1:0] next_k;
  logic [IdxWidth-1:0] next_l;

  // Tuple payload as a function of the indices. The flags and value are
  // registered from the *next* indices so they line up with k_q/l_q.
  function automatic logic [ValWidth-1:0] f_value(input logic [IdxWidth-1:0] k,
                                                   input logic [IdxWidth-1:0] l);
    f_value = (ValWidth'(1) << k) + ValWidth'(l);
  endfunction

  function automatic logic f_inner_last(input logic [IdxWidth-1:0] k,
                                        input logic [IdxWidth-1:0] l);
    f_inner_last = (l == ((IdxWidth'(1) << k) - IdxWidth'(1)));
  endfunction

  function automatic logic f_outer_last(input logic [IdxWidth-1:0] k);
    f_outer_last = (k == LastOuter);
  endfunction

  // valid_o is a register, so the transfer term never feeds back into it
  // combinationally.
  assign xfer         = valid_o & ready_i;
  assign at_inner_end = f_inner_last(k_q, l_q);
  assign at_outer_end = f_outer_last(k_q);

  always_comb begin
    next_k = k_q;
    next_l = l_q + IdxWidth'(1);
    if (at_inner_end) begin
      next_k = k_q + IdxWidth'(1);
      next_l = '0;
    end
  end

  assign outer_idx_o = k_q;
  assign inner_idx_o = l_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      k_q          <= '0;
      l_q          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      valid_o      <= 1'b0;
      value_o      <= '0;
      inner_last_o <= 1'b0;
      outer_last_o <= 1'b0;
      count_o      <= '0;
    end else if (clear_i) begin
      // Abort: a tuple accepted in this very cycle still counts, but the
      // indices are left as they are and no done pulse is produced.
      state   <= S_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      valid_o <= 1'b0;
      if (xfer) begin
        count_o <= count_o + CntWidth'(1);
      end
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state        <= S_RUN;
            k_q          <= '0;
            l_q          <= '0;
            count_o      <= '0;
            busy_o       <= 1'b1;
            valid_o      <= 1'b1;
            value_o      <= f_value('0, '0);
            inner_last_o <= f_inner_last('0, '0);
            outer_last_o <= f_outer_last('0);
          end
        end

        S_RUN: begin
          if (xfer) begin
            count_o <= count_o + CntWidth'(1);
            if (at_inner_end && at_outer_end) begin
              // Final tuple accepted: indices and payload hold their last
              // values through DONE and IDLE.
              state   <= S_DONE;
              busy_o  <= 1'b0;
              valid_o <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              k_q          <= next_k;
              l_q          <= next_l;
              value_o      <= f_value(next_k, next_l);
              inner_last_o <= f_inner_last(next_k, next_l);
              outer_last_o <= f_outer_last(next_k);
            end
          end
        end

        S_DONE: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gen_loop_walker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gen_loop_walker
// Purpose  : Directed self-checking bench for gen_loop_walker (default
//            parameters plus a NumOuter=1 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_loop_walker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clear = 1'b0, ready = 1'b0;
  logic        busy, done, valid, il, ol;
  logic [7:0]  k, l;
  logic [31:0] value;
  logic [15:0] count;

  logic        start1 = 1'b0, clear1 = 1'b0, ready1 = 1'b0;
  logic        busy1, done1, valid1, il1, ol1;
  logic [7:0]  k1, l1;
  logic [31:0] value1;
  logic [15:0] count1;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-written expected tuple sequence for NumOuter=3.
  int ek[7];
  int el[7];
  int ev[7];
  bit eil[7];
  bit eol[7];

  always #5 clk = ~clk;

  gen_loop_walker u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .busy_o(busy), .done_o(done), .valid_o(valid), .ready_i(ready),
    .outer_idx_o(k), .inner_idx_o(l), .value_o(value),
    .inner_last_o(il), .outer_last_o(ol), .count_o(count)
  );

  gen_loop_walker #(.NumOuter(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .clear_i(clear1),
    .busy_o(busy1), .done_o(done1), .valid_o(valid1), .ready_i(ready1),
    .outer_idx_o(k1), .inner_idx_o(l1), .value_o(value1),
    .inner_last_o(il1), .outer_last_o(ol1), .count_o(count1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, valid, il, ol} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, valid, il, ol}); end
    n_cmp++; if ({k, l} !== 16'h0) begin n_bad++; $display("FAIL reset_idx got=%h exp=0000", {k, l}); end
    n_cmp++; if (value !== 32'd0) begin n_bad++; $display("FAIL reset_value got=%0d exp=0", value); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if ({busy1, done1, valid1, il1, ol1, value1, count1} !== 53'd0) begin n_bad++; $display("FAIL reset_dut1 got=%h exp=0", {busy1, done1, valid1, il1, ol1, value1, count1}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ready_high();
    start = 1'b1;
    ready = 1'b1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rh_pre_valid got=%b exp=0", valid); end
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if ({valid, busy, done} !== 3'b110) begin n_bad++; $display("FAIL rh_ctrl[%0d] got=%b exp=110", i, {valid, busy, done}); end
      n_cmp++; if (k !== 8'(ek[i]) || l !== 8'(el[i])) begin n_bad++; $display("FAIL rh_idx[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, k, l, ek[i], el[i]); end
      n_cmp++; if (value !== 32'(ev[i])) begin n_bad++; $display("FAIL rh_value[%0d] got=%0d exp=%0d", i, value, ev[i]); end
      n_cmp++; if (il !== eil[i] || ol !== eol[i]) begin n_bad++; $display("FAIL rh_last[%0d] got=%b%b exp=%b%b", i, il, ol, eil[i], eol[i]); end
      n_cmp++; if (count !== 16'(i)) begin n_bad++; $display("FAIL rh_count[%0d] got=%0d exp=%0d", i, count, i); end
      step();
    end
    n_cmp++; if ({done, valid, busy} !== 3'b100) begin n_bad++; $display("FAIL rh_done got=%b exp=100", {done, valid, busy}); end
    n_cmp++; if (count !== 16'd7) begin n_bad++; $display("FAIL rh_final_count got=%0d exp=7", count); end
    n_cmp++; if (k !== 8'd2 || l !== 8'd3 || value !== 32'd7) begin n_bad++; $display("FAIL rh_hold got=(%0d,%0d,%0d) exp=(2,3,7)", k, l, value); end
    step();
    n_cmp++; if ({done, valid} !== 2'b00) begin n_bad++; $display("FAIL rh_done_once got=%b exp=00", {done, valid}); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit pat[4];
    int idx = 0;
    int cyc = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (idx < 7 && cyc < 200) begin
      ready = pat[cyc % 4];
      // Expected tuple only advances on an accepted transfer, so any
      // change during a stall, duplicate or skip shows up here.
      n_cmp++; if (valid !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL bp_ctrl[%0d] got=%b%b exp=10", cyc, valid, done); end
      n_cmp++; if (k !== 8'(ek[idx]) || l !== 8'(el[idx]) || value !== 32'(ev[idx])) begin n_bad++; $display("FAIL bp_tuple[%0d] got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", cyc, k, l, value, ek[idx], el[idx], ev[idx]); end
      if (ready) idx++;
      step();
      cyc++;
    end
    n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL bp_timeout got=%0d exp<200", cyc); end
    n_cmp++; if ({done, valid} !== 2'b10) begin n_bad++; $display("FAIL bp_done got=%b exp=10", {done, valid}); end
    n_cmp++; if (count !== 16'd7) begin n_bad++; $display("FAIL bp_count got=%0d exp=7", count); end
    ready = 1'b0;
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL bp_done_once got=%b exp=0", done); end
  endtask

  task automatic test_clear();
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      ready = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      n_cmp++; if (k !== 8'd2 || l !== 8'd0 || count !== 16'd3) begin n_bad++; $display("FAIL clr_pre[%0d] got=(%0d,%0d) cnt=%0d exp=(2,0) cnt=3", pass, k, l, count); end
      clear = 1'b1;
      ready = (pass == 1);
      step();
      clear = 1'b0;
      ready = 1'b0;
      n_cmp++; if ({valid, busy, done} !== 3'b000) begin n_bad++; $display("FAIL clr_ctrl[%0d] got=%b exp=000", pass, {valid, busy, done}); end
      n_cmp++; if (count !== 16'(3 + pass)) begin n_bad++; $display("FAIL clr_count[%0d] got=%0d exp=%0d", pass, count, 3 + pass); end
      step();
      n_cmp++; if ({valid, done} !== 2'b00 || count !== 16'(3 + pass)) begin n_bad++; $display("FAIL clr_idle[%0d] got=%b cnt=%0d exp=00 cnt=%0d", pass, {valid, done}, count, 3 + pass); end
    end
  endtask

  task automatic test_start_held();
    start = 1'b1;
    ready = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (valid !== 1'b1 || value !== 32'(ev[i]) || count !== 16'(i)) begin n_bad++; $display("FAIL sh_tuple[%0d] got=v%b %0d cnt=%0d exp=v1 %0d cnt=%0d", i, valid, value, count, ev[i], i); end
      step();
    end
    n_cmp++; if ({done, valid} !== 2'b10) begin n_bad++; $display("FAIL sh_done got=%b exp=10", {done, valid}); end
    start = 1'b0;
    step();
    step();
    n_cmp++; if ({valid, busy, done} !== 3'b000 || count !== 16'd7) begin n_bad++; $display("FAIL sh_norestart got=%b cnt=%0d exp=000 cnt=7", {valid, busy, done}, count); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (valid !== 1'b1 || count !== 16'd0 || value !== 32'd1) begin n_bad++; $display("FAIL sh_restart got=v%b cnt=%0d val=%0d exp=v1 cnt=0 val=1", valid, count, value); end
    repeat (8) step();
    ready = 1'b0;
    n_cmp++; if ({valid, done} !== 2'b00 || count !== 16'd7) begin n_bad++; $display("FAIL sh_second_walk got=%b cnt=%0d exp=00 cnt=7", {valid, done}, count); end
  endtask

  task automatic test_num_outer_one();
    start1 = 1'b1;
    ready1 = 1'b1;
    step();
    start1 = 1'b0;
    n_cmp++; if ({valid1, busy1, il1, ol1} !== 4'b1111) begin n_bad++; $display("FAIL n1_flags got=%b exp=1111", {valid1, busy1, il1, ol1}); end
    n_cmp++; if (k1 !== 8'd0 || l1 !== 8'd0 || value1 !== 32'd1) begin n_bad++; $display("FAIL n1_tuple got=(%0d,%0d,%0d) exp=(0,0,1)", k1, l1, value1); end
    step();
    n_cmp++; if ({done1, valid1} !== 2'b10 || count1 !== 16'd1) begin n_bad++; $display("FAIL n1_done got=%b cnt=%0d exp=10 cnt=1", {done1, valid1}, count1); end
    step();
    ready1 = 1'b0;
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL n1_done_once got=%b exp=0", done1); end
  endtask

  task automatic test_reset_mid_walk();
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    n_cmp++; if (k !== 8'd2 || l !== 8'd1 || value !== 32'd5) begin n_bad++; $display("FAIL rm_pre got=(%0d,%0d,%0d) exp=(2,1,5)", k, l, value); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, valid, il, ol, k, l, value, count} !== 69'd0) begin n_bad++; $display("FAIL rm_async got=%h exp=0", {busy, done, valid, il, ol, k, l, value, count}); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (valid !== 1'b1 || k !== 8'(ek[i]) || l !== 8'(el[i]) || value !== 32'(ev[i])) begin n_bad++; $display("FAIL rm_tuple[%0d] got=v%b (%0d,%0d,%0d) exp=v1 (%0d,%0d,%0d)", i, valid, k, l, value, ek[i], el[i], ev[i]); end
      step();
    end
    n_cmp++; if (done !== 1'b1 || count !== 16'd7) begin n_bad++; $display("FAIL rm_done got=%b cnt=%0d exp=1 cnt=7", done, count); end
    ready = 1'b0;
    step();
  endtask

  initial begin
    ek[0] = 0; ek[1] = 1; ek[2] = 1; ek[3] = 2; ek[4] = 2; ek[5] = 2; ek[6] = 2;
    el[0] = 0; el[1] = 0; el[2] = 1; el[3] = 0; el[4] = 1; el[5] = 2; el[6] = 3;
    for (int i = 0; i < 7; i++) ev[i] = i + 1;
    eil[0] = 1; eil[1] = 0; eil[2] = 1; eil[3] = 0; eil[4] = 0; eil[5] = 0; eil[6] = 1;
    for (int i = 0; i < 7; i++) eol[i] = (i >= 3);

    test_reset();
    test_ready_high();
    test_backpressure();
    test_clear();
    test_start_held();
    test_num_outer_one();
    test_reset_mid_walk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
